// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite memory arbiter.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW   = 3'd3,
    B    = 3'd4
  } state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_mem_arbiter_if.sv
// AXI4-Lite signal bundle; master drives requests, slave drives responses.
interface axi_lite_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_arb_pick.sv
// Combinational winner selection between the inst read and the data read/write requests.
module axi_arb_pick
  import axi_arb_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic   req_inst_rd,
  input  logic   req_data_rd,
  input  logic   req_data_wr,
  input  owner_e last_grant,
  output logic   gnt_inst_rd,
  output logic   gnt_data_rd,
  output logic   gnt_data_wr
);

  logic data_req_s;
  logic data_wins_s;

  // Data beats inst if inst is idle, in fixed-priority mode, or when inst went last.
  always_comb begin
    data_req_s  = req_data_rd | req_data_wr;
    data_wins_s = data_req_s & (~req_inst_rd | (ARB_MODE == 1) | (last_grant == INST));
    gnt_inst_rd = req_inst_rd & ~data_wins_s;
    gnt_data_rd = data_wins_s & req_data_rd;
    gnt_data_wr = data_wins_s & ~req_data_rd & req_data_wr;
  end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Serialises inst reads and data reads/writes onto one AXI4-Lite memory port, one transaction at a time.
module axi_lite_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  axi_lite_mem_arbiter_if.slave  inst_axi,
  axi_lite_mem_arbiter_if.slave  data_axi,
  axi_lite_mem_arbiter_if.master mem_axi
);
  localparam int STRB_W = DATA_W / 8;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              en_q;

  logic gnt_inst_rd_s, gnt_data_rd_s, gnt_data_wr_s;
  logic inst_arready_s, data_arready_s, data_wready_s;
  logic in_r_s, owner_rready_s;
  logic unused_s;

  axi_arb_pick #(.ARB_MODE(ARB_MODE)) u_pick (
    .req_inst_rd (inst_axi.arvalid),
    .req_data_rd (data_axi.arvalid),
    .req_data_wr (data_axi.awvalid & data_axi.wvalid),
    .last_grant  (last_grant_q),
    .gnt_inst_rd (gnt_inst_rd_s),
    .gnt_data_rd (gnt_data_rd_s),
    .gnt_data_wr (gnt_data_wr_s)
  );

  // en_q holds off grants while reset is asserted so no ready leaks out during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= INST;
      last_grant_q <= INST;
      araddr_q     <= {ADDR_W{1'b0}};
      awaddr_q     <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      wstrb_q      <= {STRB_W{1'b0}};
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      araddr_q     <= araddr_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      en_q         <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    araddr_d       = araddr_q;
    awaddr_d       = awaddr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    inst_arready_s = 1'b0;
    data_arready_s = 1'b0;
    data_wready_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q && gnt_inst_rd_s) begin
          inst_arready_s = 1'b1;
          araddr_d       = inst_axi.araddr;
          owner_d        = INST;
          last_grant_d   = INST;
          state_d        = AR;
        end else if (en_q && gnt_data_rd_s) begin
          data_arready_s = 1'b1;
          araddr_d       = data_axi.araddr;
          owner_d        = DATA;
          last_grant_d   = DATA;
          state_d        = AR;
        end else if (en_q && gnt_data_wr_s) begin
          data_wready_s  = 1'b1;
          awaddr_d       = data_axi.awaddr;
          wdata_d        = data_axi.wdata;
          wstrb_d        = data_axi.wstrb;
          aw_done_d      = 1'b0;
          w_done_d       = 1'b0;
          owner_d        = DATA;
          last_grant_d   = DATA;
          state_d        = AW;
        end else begin
          state_d = IDLE;
        end
      end
      AR: begin
        if (mem_axi.arready) state_d = R;
        else                 state_d = AR;
      end
      R: begin
        if (mem_axi.rvalid && owner_rready_s) state_d = IDLE;
        else                                  state_d = R;
      end
      AW: begin
        // AW and W complete independently; either order, or together.
        aw_done_d = aw_done_q | mem_axi.awready;
        w_done_d  = w_done_q | mem_axi.wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = B;
        end else begin
          state_d = AW;
        end
      end
      B: begin
        if (mem_axi.bvalid && data_axi.bready) state_d = IDLE;
        else                                   state_d = B;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_r_s         = (state_q == R);
  assign owner_rready_s = (owner_q == DATA) ? data_axi.rready : inst_axi.rready;

  assign inst_axi.arready = inst_arready_s;
  assign inst_axi.rvalid  = in_r_s && (owner_q == INST) && mem_axi.rvalid;
  assign inst_axi.rdata   = (in_r_s && (owner_q == INST)) ? mem_axi.rdata : {DATA_W{1'b0}};
  assign inst_axi.rresp   = (in_r_s && (owner_q == INST)) ? mem_axi.rresp : OKAY;
  assign inst_axi.awready = 1'b0;
  assign inst_axi.wready  = 1'b0;
  assign inst_axi.bvalid  = 1'b0;
  assign inst_axi.bresp   = OKAY;

  assign data_axi.arready = data_arready_s;
  assign data_axi.rvalid  = in_r_s && (owner_q == DATA) && mem_axi.rvalid;
  assign data_axi.rdata   = (in_r_s && (owner_q == DATA)) ? mem_axi.rdata : {DATA_W{1'b0}};
  assign data_axi.rresp   = (in_r_s && (owner_q == DATA)) ? mem_axi.rresp : OKAY;
  assign data_axi.awready = data_wready_s;
  assign data_axi.wready  = data_wready_s;
  assign data_axi.bvalid  = (state_q == B) && mem_axi.bvalid;
  assign data_axi.bresp   = (state_q == B) ? mem_axi.bresp : OKAY;

  assign mem_axi.araddr  = araddr_q;
  assign mem_axi.arvalid = (state_q == AR);
  assign mem_axi.rready  = in_r_s && owner_rready_s;
  assign mem_axi.awaddr  = awaddr_q;
  assign mem_axi.awvalid = (state_q == AW) && !aw_done_q;
  assign mem_axi.wdata   = wdata_q;
  assign mem_axi.wstrb   = wstrb_q;
  assign mem_axi.wvalid  = (state_q == AW) && !w_done_q;
  assign mem_axi.bready  = (state_q == B) && data_axi.bready;

  // The inst master is read-only; its write-side inputs are intentionally ignored.
  assign unused_s = ^{inst_axi.awaddr, inst_axi.awvalid, inst_axi.wdata,
                      inst_axi.wstrb, inst_axi.wvalid, inst_axi.bready};

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed self-checking bench: one round-robin arbiter instance and one fixed-priority instance.
module tb_axi_lite_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst0 ();
  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data0 ();
  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem0 ();
  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst1 ();
  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data1 ();
  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem1 ();

  axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .inst_axi(inst0), .data_axi(data0), .mem_axi(mem0));
  axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .inst_axi(inst1), .data_axi(data1), .mem_axi(mem1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    inst0.araddr = 32'h0; inst0.arvalid = 1'b0; inst0.rready = 1'b0; inst0.awaddr = 32'h0;
    inst0.awvalid = 1'b0; inst0.wdata = 32'h0; inst0.wstrb = 4'h0; inst0.wvalid = 1'b0; inst0.bready = 1'b0;
    data0.araddr = 32'h0; data0.arvalid = 1'b0; data0.rready = 1'b0; data0.awaddr = 32'h0;
    data0.awvalid = 1'b0; data0.wdata = 32'h0; data0.wstrb = 4'h0; data0.wvalid = 1'b0; data0.bready = 1'b0;
    mem0.arready = 1'b0; mem0.rdata = 32'h0; mem0.rresp = 2'b00; mem0.rvalid = 1'b0;
    mem0.awready = 1'b0; mem0.wready = 1'b0; mem0.bresp = 2'b00; mem0.bvalid = 1'b0;
    inst1.araddr = 32'h0; inst1.arvalid = 1'b0; inst1.rready = 1'b0; inst1.awaddr = 32'h0;
    inst1.awvalid = 1'b0; inst1.wdata = 32'h0; inst1.wstrb = 4'h0; inst1.wvalid = 1'b0; inst1.bready = 1'b0;
    data1.araddr = 32'h0; data1.arvalid = 1'b0; data1.rready = 1'b0; data1.awaddr = 32'h0;
    data1.awvalid = 1'b0; data1.wdata = 32'h0; data1.wstrb = 4'h0; data1.wvalid = 1'b0; data1.bready = 1'b0;
    mem1.arready = 1'b0; mem1.rdata = 32'h0; mem1.rresp = 2'b00; mem1.rvalid = 1'b0;
    mem1.awready = 1'b0; mem1.wready = 1'b0; mem1.bresp = 2'b00; mem1.bvalid = 1'b0;
  endtask

  task automatic do_reset();
    init_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    init_inputs();
    rst_n = 1'b0;
    inst0.arvalid = 1'b1; data0.awvalid = 1'b1; data0.wvalid = 1'b1;
    #1;
    checks++; if (inst0.arready !== 1'b0) begin errors++; $display("FAIL rst_inst_arready: got %b exp 0", inst0.arready); end
    checks++; if (data0.awready !== 1'b0) begin errors++; $display("FAIL rst_data_awready: got %b exp 0", data0.awready); end
    checks++; if ({mem0.arvalid, mem0.awvalid, mem0.wvalid} !== 3'b000) begin errors++; $display("FAIL rst_mem_valids: got %b exp 000", {mem0.arvalid, mem0.awvalid, mem0.wvalid}); end
    checks++; if (mem0.araddr !== 32'h0) begin errors++; $display("FAIL rst_araddr: got %h exp 0", mem0.araddr); end
    checks++; if ({mem0.awaddr, mem0.wdata, mem0.wstrb} !== 68'h0) begin errors++; $display("FAIL rst_aw_w: got %h exp 0", {mem0.awaddr, mem0.wdata, mem0.wstrb}); end
    checks++; if ({inst0.rvalid, data0.rvalid, data0.bvalid} !== 3'b000) begin errors++; $display("FAIL rst_resp_valids: got %b exp 000", {inst0.rvalid, data0.rvalid, data0.bvalid}); end
    tick();
  endtask

  task automatic test_inst_read();
    do_reset();
    inst0.arvalid = 1'b1; inst0.araddr = 32'h8000_0000;
    #1;
    checks++; if (inst0.arready !== 1'b1) begin errors++; $display("FAIL ir_c0_arready: got %b exp 1", inst0.arready); end
    checks++; if (data0.arready !== 1'b0) begin errors++; $display("FAIL ir_c0_data_arready: got %b exp 0", data0.arready); end
    tick();
    inst0.arvalid = 1'b0; mem0.arready = 1'b1;
    #1;
    checks++; if (mem0.arvalid !== 1'b1) begin errors++; $display("FAIL ir_c1_arvalid: got %b exp 1", mem0.arvalid); end
    checks++; if (mem0.araddr !== 32'h8000_0000) begin errors++; $display("FAIL ir_c1_araddr: got %h exp 80000000", mem0.araddr); end
    checks++; if (inst0.arready !== 1'b0) begin errors++; $display("FAIL ir_c1_arready: got %b exp 0", inst0.arready); end
    tick();
    mem0.arready = 1'b0; mem0.rvalid = 1'b1; mem0.rdata = 32'h0000_0013; inst0.rready = 1'b1;
    #1;
    checks++; if (inst0.rvalid !== 1'b1) begin errors++; $display("FAIL ir_c2_rvalid: got %b exp 1", inst0.rvalid); end
    checks++; if (inst0.rdata !== 32'h0000_0013) begin errors++; $display("FAIL ir_c2_rdata: got %h exp 00000013", inst0.rdata); end
    checks++; if (data0.rvalid !== 1'b0) begin errors++; $display("FAIL ir_c2_data_rvalid: got %b exp 0", data0.rvalid); end
    checks++; if (mem0.rready !== 1'b1) begin errors++; $display("FAIL ir_c2_rready: got %b exp 1", mem0.rready); end
    tick();
    mem0.rvalid = 1'b0;
    #1;
    checks++; if ({inst0.rvalid, mem0.arvalid} !== 2'b00) begin errors++; $display("FAIL ir_c3_idle: got %b exp 00", {inst0.rvalid, mem0.arvalid}); end
  endtask

  task automatic test_round_robin();
    logic exp_i, exp_d, owner_d;
    do_reset();
    inst0.arvalid = 1'b1; inst0.araddr = 32'h0000_1000; inst0.rready = 1'b1;
    data0.arvalid = 1'b1; data0.araddr = 32'h0000_2000; data0.rready = 1'b1;
    mem0.arready = 1'b1; mem0.rvalid = 1'b1; mem0.rdata = 32'h0000_00A5;
    for (int i = 0; i < 12; i++) begin
      #1;
      owner_d = ((i / 3) % 2 == 0);
      exp_d = (i % 3 == 0) && owner_d;
      exp_i = (i % 3 == 0) && !owner_d;
      checks++; if ({inst0.arready, data0.arready} !== {exp_i, exp_d}) begin errors++; $display("FAIL rr_grant c%0d: got i%b d%b exp i%b d%b", i, inst0.arready, data0.arready, exp_i, exp_d); end
      if (i % 3 == 1) begin
        checks++; if (mem0.araddr !== (owner_d ? 32'h0000_2000 : 32'h0000_1000)) begin errors++; $display("FAIL rr_araddr c%0d: got %h owner_data %b", i, mem0.araddr, owner_d); end
      end
      if (i % 3 == 2) begin
        checks++; if ({inst0.rvalid, data0.rvalid} !== {!owner_d, owner_d}) begin errors++; $display("FAIL rr_rvalid c%0d: got i%b d%b exp i%b d%b", i, inst0.rvalid, data0.rvalid, !owner_d, owner_d); end
      end
      tick();
    end
  endtask

  task automatic test_fixed_priority();
    logic exp_i, exp_d;
    do_reset();
    inst1.arvalid = 1'b1; inst1.araddr = 32'h0000_1000; inst1.rready = 1'b1;
    data1.arvalid = 1'b1; data1.araddr = 32'h0000_2000; data1.rready = 1'b1;
    mem1.arready = 1'b1; mem1.rvalid = 1'b1; mem1.rdata = 32'h0000_005A;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) data1.arvalid = 1'b0;
      #1;
      exp_d = (i % 3 == 0) && (i < 9);
      exp_i = (i == 9);
      checks++; if ({inst1.arready, data1.arready} !== {exp_i, exp_d}) begin errors++; $display("FAIL fp_grant c%0d: got i%b d%b exp i%b d%b", i, inst1.arready, data1.arready, exp_i, exp_d); end
      tick();
    end
  endtask

  task automatic test_write();
    do_reset();
    data0.awvalid = 1'b1; data0.awaddr = 32'h8000_0100;
    data0.wvalid = 1'b1; data0.wdata = 32'hDEAD_BEEF; data0.wstrb = 4'b0011; data0.bready = 1'b1;
    #1;
    checks++; if ({data0.awready, data0.wready, data0.arready} !== 3'b110) begin errors++; $display("FAIL wr_c0_readies: got %b exp 110", {data0.awready, data0.wready, data0.arready}); end
    checks++; if (inst0.awready !== 1'b0) begin errors++; $display("FAIL wr_c0_inst_awready: got %b exp 0", inst0.awready); end
    tick();
    data0.awvalid = 1'b0; data0.wvalid = 1'b0; mem0.awready = 1'b1;
    #1;
    checks++; if ({mem0.awvalid, mem0.wvalid} !== 2'b11) begin errors++; $display("FAIL wr_c1_valids: got %b exp 11", {mem0.awvalid, mem0.wvalid}); end
    checks++; if ({mem0.awaddr, mem0.wdata, mem0.wstrb} !== {32'h8000_0100, 32'hDEAD_BEEF, 4'b0011}) begin errors++; $display("FAIL wr_c1_payload: got %h %h %b exp 80000100 deadbeef 0011", mem0.awaddr, mem0.wdata, mem0.wstrb); end
    checks++; if (data0.awready !== 1'b0) begin errors++; $display("FAIL wr_c1_awready: got %b exp 0", data0.awready); end
    tick();
    mem0.awready = 1'b0;
    #1;
    checks++; if ({mem0.awvalid, mem0.wvalid} !== 2'b01) begin errors++; $display("FAIL wr_c2_valids: got %b exp 01", {mem0.awvalid, mem0.wvalid}); end
    tick();
    mem0.wready = 1'b1;
    #1;
    checks++; if ({mem0.awvalid, mem0.wvalid, data0.bvalid} !== 3'b010) begin errors++; $display("FAIL wr_c3_valids: got %b exp 010", {mem0.awvalid, mem0.wvalid, data0.bvalid}); end
    tick();
    mem0.wready = 1'b0; mem0.bvalid = 1'b1; mem0.bresp = 2'b00;
    #1;
    checks++; if ({data0.bvalid, data0.bresp, mem0.bready} !== 4'b1001) begin errors++; $display("FAIL wr_c4_b: got %b exp 1001", {data0.bvalid, data0.bresp, mem0.bready}); end
    checks++; if ({inst0.rvalid, inst0.bvalid, inst0.arready, inst0.wready} !== 4'b0000) begin errors++; $display("FAIL wr_c4_inst_quiet: got %b exp 0000", {inst0.rvalid, inst0.bvalid, inst0.arready, inst0.wready}); end
    tick();
    mem0.bvalid = 1'b0;
    #1;
    checks++; if ({data0.bvalid, mem0.wvalid, mem0.bready} !== 3'b000) begin errors++; $display("FAIL wr_c5_idle: got %b exp 000", {data0.bvalid, mem0.wvalid, mem0.bready}); end
  endtask

  task automatic test_read_over_write();
    do_reset();
    data0.arvalid = 1'b1; data0.araddr = 32'h0000_0040;
    data0.awvalid = 1'b1; data0.wvalid = 1'b1; data0.awaddr = 32'h0000_0080;
    #1;
    checks++; if ({data0.arready, data0.awready, data0.wready} !== 3'b100) begin errors++; $display("FAIL rw_prio: got %b exp 100", {data0.arready, data0.awready, data0.wready}); end
    tick();
    data0.arvalid = 1'b0; data0.awvalid = 1'b0; data0.wvalid = 1'b0;
    #1;
    checks++; if ({mem0.arvalid, mem0.awvalid} !== 2'b10) begin errors++; $display("FAIL rw_prio_state: got %b exp 10", {mem0.arvalid, mem0.awvalid}); end
  endtask

  task automatic test_slverr();
    do_reset();
    inst0.arvalid = 1'b1; inst0.araddr = 32'h0000_0500; inst0.rready = 1'b1;
    tick();
    inst0.arvalid = 1'b0; mem0.arready = 1'b1;
    tick();
    mem0.arready = 1'b0; mem0.rvalid = 1'b1; mem0.rresp = 2'b10; mem0.rdata = 32'h0000_0BAD;
    #1;
    checks++; if ({inst0.rvalid, inst0.rresp} !== 3'b110) begin errors++; $display("FAIL se_inst_rresp: got %b exp 110", {inst0.rvalid, inst0.rresp}); end
    tick();
    mem0.rvalid = 1'b0; mem0.rresp = 2'b00;
    data0.arvalid = 1'b1; data0.araddr = 32'h0000_0600; data0.rready = 1'b1;
    #1;
    checks++; if (data0.arready !== 1'b1) begin errors++; $display("FAIL se_data_grant: got %b exp 1", data0.arready); end
    tick();
    data0.arvalid = 1'b0; mem0.arready = 1'b1;
    #1;
    checks++; if (mem0.araddr !== 32'h0000_0600) begin errors++; $display("FAIL se_data_araddr: got %h exp 00000600", mem0.araddr); end
    tick();
    mem0.arready = 1'b0; mem0.rvalid = 1'b1; mem0.rdata = 32'h0000_0055;
    #1;
    checks++; if ({data0.rvalid, data0.rresp, data0.rdata} !== {1'b1, 2'b00, 32'h0000_0055}) begin errors++; $display("FAIL se_data_r: got %b %b %h exp 1 00 00000055", data0.rvalid, data0.rresp, data0.rdata); end
    checks++; if (inst0.rvalid !== 1'b0) begin errors++; $display("FAIL se_inst_quiet: got %b exp 0", inst0.rvalid); end
    tick();
    mem0.rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst0.arvalid = 1'b1; inst0.araddr = 32'h0000_0300;
    tick();
    inst0.arvalid = 1'b0; mem0.arready = 1'b1;
    tick();
    mem0.arready = 1'b0; mem0.rvalid = 1'b1; mem0.rdata = 32'h0000_0077; inst0.rready = 1'b0;
    #1;
    checks++; if (inst0.rvalid !== 1'b1) begin errors++; $display("FAIL rm_in_r: got %b exp 1", inst0.rvalid); end
    rst_n = 1'b0;
    inst0.arvalid = 1'b1;
    #1;
    checks++; if ({inst0.rvalid, inst0.rdata} !== 33'h0) begin errors++; $display("FAIL rm_r_cleared: got %b %h exp 0 0", inst0.rvalid, inst0.rdata); end
    checks++; if ({mem0.rready, mem0.arvalid, mem0.araddr, inst0.arready} !== 35'h0) begin errors++; $display("FAIL rm_outs_cleared: got %b %b %h %b exp 0", mem0.rready, mem0.arvalid, mem0.araddr, inst0.arready); end
    inst0.arvalid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    checks++; if ({inst0.rvalid, mem0.rready} !== 2'b00) begin errors++; $display("FAIL rm_no_stale_resp: got %b exp 00", {inst0.rvalid, mem0.rready}); end
    mem0.rvalid = 1'b0;
    inst0.arvalid = 1'b1; inst0.araddr = 32'h0000_0400; inst0.rready = 1'b1;
    #1;
    checks++; if (inst0.arready !== 1'b1) begin errors++; $display("FAIL rm_fresh_grant: got %b exp 1", inst0.arready); end
    tick();
    inst0.arvalid = 1'b0; mem0.arready = 1'b1;
    #1;
    checks++; if ({mem0.arvalid, mem0.araddr} !== {1'b1, 32'h0000_0400}) begin errors++; $display("FAIL rm_fresh_ar: got %b %h exp 1 00000400", mem0.arvalid, mem0.araddr); end
    tick();
    mem0.arready = 1'b0; mem0.rvalid = 1'b1; mem0.rdata = 32'h0000_0099;
    #1;
    checks++; if ({inst0.rvalid, inst0.rdata} !== {1'b1, 32'h0000_0099}) begin errors++; $display("FAIL rm_fresh_r: got %b %h exp 1 00000099", inst0.rvalid, inst0.rdata); end
    tick();
    mem0.rvalid = 1'b0;
    #1;
    checks++; if ({inst0.rvalid, mem0.arvalid} !== 2'b00) begin errors++; $display("FAIL rm_fresh_done: got %b exp 00", {inst0.rvalid, mem0.arvalid}); end
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_round_robin();
    test_fixed_priority();
    test_write();
    test_read_over_write();
    test_slverr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
